// File: rtl/controlador_display_mux.sv
// Time-multiplexed seven-segment driver: scans N_DIGITOS digits from shadow-registered
// hex nibbles, with optional leading-zero blanking and per-digit decimal points.
module controlador_display_mux #(
  parameter int N_DIGITOS    = 4,
  parameter int DIV_REFRESCO = 100000,
  parameter int ACTIVO_BAJO  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   habilitar,
  input  logic                   supr_ceros,
  input  logic                   carga,
  input  logic [4*N_DIGITOS-1:0] cuenta,
  input  logic [N_DIGITOS-1:0]   punto,
  output logic [N_DIGITOS-1:0]   anodo,
  output logic [7:0]             catodo
);

  localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int PRE_W = $clog2(DIV_REFRESCO);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV_REFRESCO - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITOS - 1);
  localparam logic             POL     = (ACTIVO_BAJO != 0);

  logic [PRE_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [4*N_DIGITOS-1:0] cuenta_q;
  logic [N_DIGITOS-1:0]   punto_q;
  logic [N_DIGITOS-1:0]   anodo_q, anodo_d;
  logic [7:0]             catodo_q, catodo_d;

  logic                   tick;
  logic [N_DIGITOS-1:0]   sel;
  logic [N_DIGITOS-1:0]   apagado;
  logic [N_DIGITOS:1]     ceros_sup;
  logic [3:0]             nibble;
  logic                   dp_sel;
  logic                   apagado_sel;
  logic [6:0]             seg7;
  logic [7:0]             seg_hi;

  assign tick    = (presc_q == PRE_MAX);
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign idx_d   = !tick ? idx_q : ((idx_q == IDX_MAX) ? '0 : idx_q + 1'b1);

  // ceros_sup[i] is set when shadow nibbles i..N_DIGITOS-1 are all zero.
  assign ceros_sup[N_DIGITOS] = 1'b1;
  assign apagado[0]           = 1'b0;

  for (genvar gi = 1; gi < N_DIGITOS; gi++) begin : g_ceros
    assign ceros_sup[gi] = (cuenta_q[4*gi +: 4] == 4'h0) && ceros_sup[gi+1];
    assign apagado[gi]   = supr_ceros && ceros_sup[gi];
  end

  for (genvar gi = 0; gi < N_DIGITOS; gi++) begin : g_sel
    assign sel[gi] = (idx_q == IDX_W'(gi));
  end

  always_comb begin
    nibble      = 4'h0;
    dp_sel      = 1'b0;
    apagado_sel = 1'b0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (sel[i]) begin
        nibble      = cuenta_q[4*i +: 4];
        dp_sel      = punto_q[i];
        apagado_sel = apagado[i];
      end
    end
  end

  always_comb begin
    case (nibble)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  end

  // A blanked digit keeps its anode but darkens every segment, dp included.
  assign seg_hi   = apagado_sel ? 8'h00 : {dp_sel, seg7};
  assign anodo_d  = sel ^ {N_DIGITOS{POL}};
  assign catodo_d = seg_hi ^ {8{POL}};

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      cuenta_q <= '0;
      punto_q  <= '0;
      anodo_q  <= {N_DIGITOS{POL}};
      catodo_q <= {8{POL}};
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (carga) begin
        cuenta_q <= cuenta;
        punto_q  <= punto;
      end
      if (habilitar) begin
        anodo_q  <= anodo_d;
        catodo_q <= catodo_d;
      end else begin
        anodo_q  <= {N_DIGITOS{POL}};
        catodo_q <= {8{POL}};
      end
    end
  end

  assign anodo  = anodo_q;
  assign catodo = catodo_q;

endmodule

// File: tb/tb_controlador_display_mux.sv
// Directed bench for controlador_display_mux with 4 digits, 4-cycle refresh, active-low levels.
module tb_controlador_display_mux;

  logic        clk = 1'b0;
  logic        reset, habilitar, supr_ceros, carga;
  logic [15:0] cuenta;
  logic [3:0]  punto;
  logic [3:0]  anodo;
  logic [7:0]  catodo;

  int n_checks = 0;
  int n_pass   = 0;
  int ciclo    = 0;   // edges since the last reset release
  logic [7:0] tabla [4];

  controlador_display_mux #(
    .N_DIGITOS   (4),
    .DIV_REFRESCO(4),
    .ACTIVO_BAJO (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .habilitar (habilitar),
    .supr_ceros(supr_ceros),
    .carga     (carga),
    .cuenta    (cuenta),
    .punto     (punto),
    .anodo     (anodo),
    .catodo    (catodo)
  );

  always #5 clk = ~clk;

  task automatic verificar(input string tag, input logic [7:0] obs, input logic [7:0] esp);
    n_checks++;
    if (obs === esp) begin
      n_pass++;
      $display("ok   %s ciclo=%0d got=%h", tag, ciclo, obs);
    end else begin
      $display("FAIL %s ciclo=%0d got=%h expected=%h", tag, ciclo, obs, esp);
    end
  endtask

  task automatic avanzar();
    @(posedge clk);
    #1;
    ciclo++;
  endtask

  // Edge k after release shows digit ((k-1)/4) mod 4, each held 4 cycles.
  task automatic check_scan(input string tag);
    int d;
    logic [3:0] an_esp;
    d = ((ciclo - 1) / 4) % 4;
    an_esp = ~(4'b0001 << d);
    verificar({tag, "_an"}, {4'h0, anodo}, {4'h0, an_esp});
    verificar({tag, "_cat"}, catodo, tabla[d]);
  endtask

  task automatic cargar(input logic [15:0] c, input logic [3:0] p, input logic s);
    cuenta = c; punto = p; supr_ceros = s; carga = 1'b1;
    avanzar();
    carga = 1'b0;
    avanzar();
  endtask

  initial begin
    reset = 1'b1; habilitar = 1'b1; supr_ceros = 1'b0; carga = 1'b0;
    cuenta = 16'h0; punto = 4'h0;

    // Reset state and first digit after release
    @(posedge clk); #1;
    @(posedge clk); #1;
    verificar("rst_an", {4'h0, anodo}, 8'h0F);
    verificar("rst_cat", catodo, 8'hFF);
    reset = 1'b0; ciclo = 0;
    avanzar();
    verificar("rel_an", {4'h0, anodo}, 8'h0E);
    verificar("rel_cat", catodo, 8'hC0);

    // Load 1234; the load edge itself still shows the old shadow
    cuenta = 16'h1234; carga = 1'b1;
    avanzar();
    carga = 1'b0;
    verificar("lat_cat", catodo, 8'hC0);
    tabla = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    avanzar();
    check_scan("scan");

    // Input changes without carga must not reach the display
    cuenta = 16'h9999;
    while (ciclo < 23) begin
      avanzar();
      check_scan("hold");
    end
    // carga coincident with a tick: new digit shows new data on the next edge
    carga = 1'b1;
    avanzar();
    check_scan("hold_last");
    carga = 1'b0;
    tabla = '{8'h90, 8'h90, 8'h90, 8'h90};
    repeat (8) begin
      avanzar();
      check_scan("nines");
    end

    // Leading-zero blanking
    cargar(16'h0005, 4'h0, 1'b1);
    tabla = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
    repeat (16) begin avanzar(); check_scan("blank5"); end
    cargar(16'h0000, 4'h0, 1'b1);
    tabla = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    repeat (16) begin avanzar(); check_scan("blank0"); end
    supr_ceros = 1'b0;
    avanzar();
    tabla = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    repeat (16) begin avanzar(); check_scan("noblank"); end

    // Decimal point, and dp suppressed on a blanked digit
    cargar(16'h1234, 4'b0100, 1'b0);
    tabla = '{8'h99, 8'hB0, 8'h24, 8'hF9};
    repeat (16) begin avanzar(); check_scan("dp"); end
    cargar(16'h0034, 4'b0100, 1'b1);
    tabla = '{8'h99, 8'hB0, 8'hFF, 8'hFF};
    repeat (16) begin avanzar(); check_scan("dp_blank"); end

    // Disable while the next edge would drive digit 2, then resume
    while (((ciclo / 4) % 4) != 2) avanzar();
    habilitar = 1'b0;
    avanzar();
    verificar("dis_an", {4'h0, anodo}, 8'h0F);
    verificar("dis_cat", catodo, 8'hFF);
    habilitar = 1'b1;
    repeat (6) begin avanzar(); check_scan("resume"); end

    // Reset while the next edge would drive digit 3
    while (((ciclo / 4) % 4) != 3) avanzar();
    reset = 1'b1;
    avanzar();
    verificar("mrst_an", {4'h0, anodo}, 8'h0F);
    verificar("mrst_cat", catodo, 8'hFF);
    reset = 1'b0; ciclo = 0;
    avanzar();
    verificar("mrel_an", {4'h0, anodo}, 8'h0E);
    verificar("mrel_cat", catodo, 8'hC0);
    tabla = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    repeat (8) begin avanzar(); check_scan("post_rst"); end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
